// File: rtl/pipe_share_pkg.sv
// rtl/pipe_share_pkg.sv - shared types and helpers for the pipeline-sharing arbiter
package pipe_share_pkg;

   // Widest requester id a tag can carry; the top narrows to $clog2(N_REQ) internally.
   localparam int TAG_ID_W = 8;

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   // Round-robin successor of a granted index, wrapping at n.
   function automatic int unsigned next_rr_ptr(input int unsigned g, input int unsigned n);
      return (g + 32'd1 >= n) ? 32'd0 : g + 32'd1;
   endfunction

endpackage

// File: rtl/tag_shift_register_with_valid.sv
// rtl/tag_shift_register_with_valid.sv - valid-qualified shift register for owner tags
module tag_shift_register_with_valid #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];

   // Shift valids every cycle; payload moves only behind a valid so idle stages do not toggle.
   always_comb begin
      vld_d[0]  = in_vld;
      data_d[0] = in_vld ? in_data : data_q[0];
      for (int k = 1; k < DEPTH; k++) begin
         vld_d[k]  = vld_q[k-1];
         data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
      end
   end

   // Valid chain is cleared by reset so in-flight tags are discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   // Payload storage is not reset; it is meaningless while its valid is low.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign out_vld  = vld_q[DEPTH-1];
   assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/pipe_share_arbiter.sv
// rtl/pipe_share_arbiter.sv - round-robin sharing of one fixed-latency pipeline among requesters
module pipe_share_arbiter
   import pipe_share_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int W_IN      = 32,
   parameter int W_OUT     = 32,
   parameter int LATENCY   = 4,
   parameter int MAX_OUTST = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_vld,
   input  logic [N_REQ*W_IN-1:0] req_data,
   output logic [N_REQ-1:0]      req_rdy,
   output logic                  pipe_in_vld,
   output logic [W_IN-1:0]       pipe_in_data,
   input  logic                  pipe_out_vld,
   input  logic [W_OUT-1:0]      pipe_out_data,
   output logic [N_REQ-1:0]      rsp_vld,
   output logic [W_OUT-1:0]      rsp_data,
   output logic                  err
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q [N_REQ];
   logic [CNT_W-1:0] cnt_d [N_REQ];
   logic             pipe_in_vld_q, pipe_in_vld_d;
   logic [W_IN-1:0]  pipe_in_data_q, pipe_in_data_d;
   logic [ID_W-1:0]  issue_id_q, issue_id_d;
   logic             err_q, err_d;

   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] grant;
   logic             grant_vld;
   logic [ID_W-1:0]  grant_id;
   int               idx;

   logic             tag_out_vld;
   logic [ID_W-1:0]  tag_out_id;
   tag_t             tag_last;
   logic [N_REQ-1:0] rsp_vec;

   // Round-robin search from ptr upward; only counters and req_vld feed it, never pipe_out_*.
   always_comb begin
      eligible  = '0;
      grant     = '0;
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         eligible[i] = req_vld[i] && (cnt_q[i] < CNT_MAX);
      end
      for (int off = 0; off < N_REQ; off++) begin
         idx = int'(ptr_q) + off;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (!grant_vld && (idx == i) && eligible[i]) begin
               grant_vld = 1'b1;
               grant[i]  = 1'b1;
               grant_id  = ID_W'(i);
            end
         end
      end
   end

   // Issue stage inputs and pointer advance; data and id hold when nothing is granted.
   always_comb begin
      pipe_in_vld_d  = grant_vld;
      pipe_in_data_d = pipe_in_data_q;
      issue_id_d     = issue_id_q;
      ptr_d          = ptr_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            pipe_in_data_d = req_data[i*W_IN +: W_IN];
         end
      end
      if (grant_vld) begin
         issue_id_d = grant_id;
         ptr_d      = ID_W'(next_rr_ptr(32'(grant_id), N_REQ));
      end
   end

   tag_shift_register_with_valid #(
      .WIDTH (ID_W),
      .DEPTH (LATENCY)
   ) u_tag_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (pipe_in_vld_q),
      .in_data  (issue_id_q),
      .out_vld  (tag_out_vld),
      .out_data (tag_out_id)
   );

   // Route results to their owner, track outstanding counts and flag tag/result disagreement.
   always_comb begin
      tag_last.vld = tag_out_vld;
      tag_last.id  = TAG_ID_W'(tag_out_id);
      rsp_vec      = '0;
      err_d        = err_q | (tag_last.vld ^ pipe_out_vld);
      for (int i = 0; i < N_REQ; i++) begin
         rsp_vec[i] = tag_last.vld & pipe_out_vld & (tag_last.id == TAG_ID_W'(i));
         cnt_d[i]   = cnt_q[i];
         if ((req_vld[i] & grant[i]) && !rsp_vec[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (!(req_vld[i] & grant[i]) && rsp_vec[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
         end
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q         <= '0;
         pipe_in_vld_q <= 1'b0;
         err_q         <= 1'b0;
         for (int i = 0; i < N_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         ptr_q         <= ptr_d;
         pipe_in_vld_q <= pipe_in_vld_d;
         err_q         <= err_d;
         cnt_q         <= cnt_d;
      end
   end

   // Issue payload registers are qualified by pipe_in_vld and left unreset.
   always_ff @(posedge clk) begin
      pipe_in_data_q <= pipe_in_data_d;
      issue_id_q     <= issue_id_d;
   end

   assign req_rdy      = grant;
   assign pipe_in_vld  = pipe_in_vld_q;
   assign pipe_in_data = pipe_in_data_q;
   assign rsp_vld      = rsp_vec;
   assign rsp_data     = pipe_out_data;
   assign err          = err_q;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// tb/tb_pipe_share_arbiter.sv - directed self-checking bench for pipe_share_arbiter
module tb_pipe_share_arbiter;

   localparam int NR  = 3;
   localparam int LAT = 4;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_vld;
   logic [NR*32-1:0] req_data;
   logic [NR-1:0]    req_rdy;
   logic             pipe_in_vld;
   logic [31:0]      pipe_in_data;
   logic             pipe_out_vld;
   logic [31:0]      pipe_out_data;
   logic [NR-1:0]    rsp_vld;
   logic [31:0]      rsp_data;
   logic             err;

   logic             inject;
   logic             sv [LAT];
   logic [31:0]      sd [LAT];
   logic [31:0]      dval [NR];

   int n_pass;
   int n_fail;
   int n_total;

   pipe_share_arbiter #(
      .N_REQ     (NR),
      .W_IN      (32),
      .W_OUT     (32),
      .LATENCY   (LAT),
      .MAX_OUTST (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_vld       (req_vld),
      .req_data      (req_data),
      .req_rdy       (req_rdy),
      .pipe_in_vld   (pipe_in_vld),
      .pipe_in_data  (pipe_in_data),
      .pipe_out_vld  (pipe_out_vld),
      .pipe_out_data (pipe_out_data),
      .rsp_vld       (rsp_vld),
      .rsp_data      (rsp_data),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pipeline model: LAT-cycle delay, result = input + 1, cleared with the arbiter.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) sv[k] <= 1'b0;
      end else begin
         sv[0] <= pipe_in_vld;
         for (int k = 1; k < LAT; k++) sv[k] <= sv[k-1];
      end
   end

   always @(posedge clk) begin
      sd[0] <= pipe_in_data + 32'd1;
      for (int k = 1; k < LAT; k++) sd[k] <= sd[k-1];
   end

   assign pipe_out_vld  = sv[LAT-1] | inject;
   assign pipe_out_data = sd[LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int i, input logic [31:0] v);
      req_data[i*32 +: 32] = v;
   endtask

   initial begin
      n_pass   = 0;
      n_fail   = 0;
      n_total  = 0;
      rst_n    = 1'b1;
      req_vld  = '0;
      req_data = '0;
      inject   = 1'b0;
      dval[0]  = 32'hA0;
      dval[1]  = 32'hB0;
      dval[2]  = 32'hC0;

      // reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_pipe_in_vld", 32'(pipe_in_vld), 32'd0);
      chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // single request from requester 0
      tick();
      req_vld = 3'b001;
      set_data(0, 32'h10);
      #1 chk("single_rdy", 32'(req_rdy), 32'b001);
      tick();
      req_vld = '0;
      #1;
      chk("single_pin_vld", 32'(pipe_in_vld), 32'd1);
      chk("single_pin_data", pipe_in_data, 32'h10);
      chk("single_rdy_idle", 32'(req_rdy), 32'd0);
      for (int t = 2; t <= 5; t++) begin
         tick();
         #1;
         if (t == 4) chk("single_no_rsp_early", 32'(rsp_vld), 32'd0);
         if (t == 5) begin
            chk("single_rsp_vld", 32'(rsp_vld), 32'b001);
            chk("single_rsp_data", rsp_data, 32'h11);
         end
      end

      // all requesters valid: rotation starts at ptr=1
      for (int i = 0; i < NR; i++) set_data(i, dval[i]);
      for (int k = 0; k <= 8; k++) begin
         tick();
         req_vld = 3'b111;
         #1;
         chk("rot_rdy", 32'(req_rdy), 32'(1 << ((k + 1) % 3)));
         if (k >= 1) chk("rot_pin_vld", 32'(pipe_in_vld), 32'd1);
         if (k >= 5) begin
            chk("rot_rsp_vld", 32'(rsp_vld), 32'(1 << ((k - 4) % 3)));
            chk("rot_rsp_data", rsp_data, dval[(k - 4) % 3] + 32'd1);
         end
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         req_vld = '0;
      end

      // requester 1 alone: outstanding cap of 2
      set_data(1, 32'h55);
      for (int k = 0; k <= 8; k++) begin
         tick();
         req_vld = 3'b010;
         #1;
         chk("cap_rdy", 32'(req_rdy), (k == 0 || k == 1 || k == 6 || k == 7) ? 32'b010 : 32'd0);
         if (k == 5 || k == 6) begin
            chk("cap_rsp_vld", 32'(rsp_vld), 32'b010);
            chk("cap_rsp_data", rsp_data, 32'h56);
         end
      end
      for (int k = 0; k < 7; k++) begin
         tick();
         req_vld = '0;
      end

      // requester 0: accept and response in the same cycle keep cnt at 1
      set_data(0, 32'h20);
      for (int k = 0; k <= 7; k++) begin
         tick();
         req_vld = (k == 0 || k >= 5) ? 3'b001 : 3'b000;
         #1;
         if (k == 0) chk("simul_first_rdy", 32'(req_rdy), 32'b001);
         if (k == 5) begin
            chk("simul_rdy", 32'(req_rdy), 32'b001);
            chk("simul_rsp_vld", 32'(rsp_vld), 32'b001);
            chk("simul_rsp_data", rsp_data, 32'h21);
         end
         if (k == 6) chk("simul_after_rdy", 32'(req_rdy), 32'b001);
         if (k == 7) chk("simul_capped_rdy", 32'(req_rdy), 32'd0);
      end
      for (int k = 0; k < 7; k++) begin
         tick();
         req_vld = '0;
      end

      // untagged result raises sticky err
      tick();
      inject = 1'b1;
      #1;
      chk("inject_no_rsp", 32'(rsp_vld), 32'd0);
      chk("inject_err_before", 32'(err), 32'd0);
      tick();
      inject = 1'b0;
      #1 chk("inject_err_set", 32'(err), 32'd1);
      tick();
      tick();
      #1 chk("inject_err_held", 32'(err), 32'd1);

      // reset while tags are in flight
      for (int k = 0; k <= 3; k++) begin
         tick();
         req_vld = 3'b111;
         #1 chk("mid_rdy", 32'(req_rdy), 32'(1 << ((k + 1) % 3)));
      end
      tick();
      #1;
      chk("mid_pin_vld_pre", 32'(pipe_in_vld), 32'd1);
      chk("mid_err_pre", 32'(err), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_pin_vld_rst", 32'(pipe_in_vld), 32'd0);
      chk("mid_rsp_vld_rst", 32'(rsp_vld), 32'd0);
      chk("mid_err_rst", 32'(err), 32'd0);
      chk("mid_rdy_ptr0", 32'(req_rdy), 32'b001);
      tick();
      req_vld = '0;
      #2 rst_n = 1'b1;
      for (int k = 0; k <= 2; k++) begin
         tick();
         req_vld = 3'b010;
         #1;
         chk("post_rdy", 32'(req_rdy), (k < 2) ? 32'b010 : 32'd0);
         chk("post_rsp_vld", 32'(rsp_vld), 32'd0);
         chk("post_err", 32'(err), 32'd0);
      end
      tick();
      req_vld = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
